// File: rtl/uart_bist_pkg.sv
// Shared types and defaults for the UART loopback BIST sequencer.
package uart_bist_pkg;

  localparam int CNT_W              = 16;
  localparam int DEF_NUM_BYTES      = 256;
  localparam int DEF_TIMEOUT_CYCLES = 100000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/uart_bist_ctrl.sv
// BIST sequencer: sends LFSR bytes through the UART loopback, compares the
// returned bytes and reports error/byte counts plus a pass flag.
module uart_bist_ctrl
  import uart_bist_pkg::*;
#(
  parameter int NUM_BYTES      = DEF_NUM_BYTES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             i_Clock,
  input  logic             i_Rst_L,
  input  logic             i_Start,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Pass,
  output logic [CNT_W-1:0] o_Err_Count,
  output logic [CNT_W-1:0] o_Byte_Count,
  output logic             o_Gen_Enable,
  input  logic [7:0]       i_Gen_Byte,
  output logic             o_Tx_DV,
  output logic [7:0]       o_Tx_Byte,
  input  logic             i_Tx_Done,
  input  logic             i_Rx_DV,
  input  logic [7:0]       i_Rx_Byte
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] NB       = CNT_W'(NUM_BYTES);

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               tx_seen_q, tx_seen_d;
  logic               rx_seen_q, rx_seen_d;
  logic [7:0]         rx_byte_q, rx_byte_d;
  logic [7:0]         exp_byte_q, exp_byte_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   byte_q, byte_d;
  logic               pass_q, pass_d;
  logic               tx_dv_q, tx_dv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               expired;

  // tmo_q counts clocks since the TX strobe (0 during SEND), so WAIT ends
  // exactly TIMEOUT_CYCLES clocks after o_Tx_DV.
  assign expired = (tmo_q >= TMO_LAST);

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    tx_seen_d  = tx_seen_q;
    rx_seen_d  = rx_seen_q;
    rx_byte_d  = rx_byte_q;
    exp_byte_d = exp_byte_q;
    tx_byte_d  = tx_byte_q;
    err_d      = err_q;
    byte_d     = byte_q;
    pass_d     = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          err_d   = '0;
          byte_d  = '0;
          pass_d  = 1'b0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        tmo_d   = tmo_q + TMO_W'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (i_Tx_Done) tx_seen_d = 1'b1;
        if (i_Rx_DV && !rx_seen_q) begin
          rx_seen_d = 1'b1;
          rx_byte_d = i_Rx_Byte;
        end
        if ((tx_seen_d && rx_seen_d) || expired) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if ((!rx_seen_q || (rx_byte_q != exp_byte_q)) && (err_q != '1))
          err_d = err_q + CNT_W'(1);
        byte_d = byte_q + CNT_W'(1);
        if (byte_d == NB) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Capture the generator byte on entry to SEND so o_Tx_Byte is already
    // valid while o_Tx_DV is high; the LFSR advances at the end of SEND.
    if (state_d == ST_SEND) begin
      exp_byte_d = i_Gen_Byte;
      tx_byte_d  = i_Gen_Byte;
      tmo_d      = '0;
      tx_seen_d  = 1'b0;
      rx_seen_d  = 1'b0;
    end

    tx_dv_d = (state_d == ST_SEND);
    busy_d  = (state_d == ST_SEND) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      tx_seen_q  <= 1'b0;
      rx_seen_q  <= 1'b0;
      rx_byte_q  <= '0;
      exp_byte_q <= '0;
      tx_byte_q  <= '0;
      err_q      <= '0;
      byte_q     <= '0;
      pass_q     <= 1'b0;
      tx_dv_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      tx_seen_q  <= tx_seen_d;
      rx_seen_q  <= rx_seen_d;
      rx_byte_q  <= rx_byte_d;
      exp_byte_q <= exp_byte_d;
      tx_byte_q  <= tx_byte_d;
      err_q      <= err_d;
      byte_q     <= byte_d;
      pass_q     <= pass_d;
      tx_dv_q    <= tx_dv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_Busy       = busy_q;
  assign o_Done       = done_q;
  assign o_Pass       = pass_q;
  assign o_Err_Count  = err_q;
  assign o_Byte_Count = byte_q;
  assign o_Gen_Enable = tx_dv_q;
  assign o_Tx_DV      = tx_dv_q;
  assign o_Tx_Byte    = tx_byte_q;

endmodule

// File: tb/tb_uart_bist_ctrl.sv
// Directed bench: LFSR source plus a delayed TX->RX loopback responder,
// driven from a table of run scenarios and a few hand-written sequences.
module tb_uart_bist_ctrl;

  localparam int NB  = 4;
  localparam int TMO = 50;

  typedef struct {
    int tx_dly;     // cycles from o_Tx_DV to i_Tx_Done
    int rx_dly;     // cycles from o_Tx_DV to i_Rx_DV
    int corrupt;    // byte index XORed with 8'h01 (-1 none)
    int drop;       // byte index never returned (-1 none)
    int start_mid;  // pulse i_Start during WAIT
    int exp_err;
    int exp_pass;
    int exp_tx;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, start;
  logic        busy, done, pass, gen_en, tx_dv;
  logic [15:0] err_cnt, byte_cnt;
  logic [7:0]  tx_byte, gen_byte;
  logic        tx_done_m = 1'b0, rx_dv_m = 1'b0, rx_dv_s = 1'b0, rx_dv;
  logic [7:0]  rx_byte_m = 8'h00, rx_byte_s = 8'h00, rx_byte;
  logic [15:0] lfsr = 16'hACE1;
  logic [15:0] exp_lfsr = 16'hACE1;

  int n_vec = 0, n_miss = 0;
  int cyc = 0;

  int tx_dly = 10, rx_dly = 10, corrupt_idx = -1, drop_idx = -1, start_mid = 0;
  int tx_cd = 0, rx_cd = 0, cur_idx = 0, tx_cnt = 0, done_cnt = 0;
  int dv_at[16], cnt_at[16];
  logic [15:0] last_bc = 16'h0;
  logic [7:0]  held = 8'h00;
  logic [7:0]  tx_log[$];

  assign start   = start_a | start_b;
  assign rx_dv   = rx_dv_m | rx_dv_s;
  assign rx_byte = rx_dv_s ? rx_byte_s : rx_byte_m;
  assign gen_byte = lfsr[7:0];

  uart_bist_ctrl #(.NUM_BYTES(NB), .TIMEOUT_CYCLES(TMO)) dut (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Start(start),
    .o_Busy(busy), .o_Done(done), .o_Pass(pass),
    .o_Err_Count(err_cnt), .o_Byte_Count(byte_cnt),
    .o_Gen_Enable(gen_en), .i_Gen_Byte(gen_byte),
    .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte), .i_Tx_Done(tx_done_m),
    .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gen_en) lfsr <= lfsr_step(lfsr);
  end

  // Loopback responder and event recorder, sampling mid-cycle.
  always @(negedge clk) begin
    tx_done_m = 1'b0;
    rx_dv_m   = 1'b0;
    start_b   = 1'b0;
    if (done) done_cnt++;
    if (byte_cnt != last_bc) begin
      if (byte_cnt != 0 && byte_cnt <= 16) cnt_at[byte_cnt-1] = cyc;
      last_bc = byte_cnt;
    end
    if (tx_dv) begin
      tx_log.push_back(tx_byte);
      held    = tx_byte;
      cur_idx = tx_cnt;
      if (tx_cnt < 16) dv_at[tx_cnt] = cyc;
      tx_cnt++;
      tx_cd = tx_dly;
      rx_cd = rx_dly;
    end else begin
      if (tx_cd > 0) begin
        tx_cd--;
        if (tx_cd == 0) tx_done_m = 1'b1;
      end
      if (rx_cd > 0) begin
        rx_cd--;
        if (rx_cd == 0 && cur_idx != drop_idx) begin
          rx_dv_m   = 1'b1;
          rx_byte_m = held ^ ((cur_idx == corrupt_idx) ? 8'h01 : 8'h00);
        end
        if (start_mid != 0 && rx_cd == 5) start_b = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_tx_log(input string nm);
    foreach (tx_log[i]) begin
      chk($sformatf("%s_txbyte%0d", nm, i), tx_log[i], exp_lfsr[7:0]);
      exp_lfsr = lfsr_step(exp_lfsr);
    end
    tx_log.delete();
  endtask

  task automatic run_vec(input vec_t v, input string nm, input bit first);
    int k;
    tx_dly = v.tx_dly; rx_dly = v.rx_dly;
    corrupt_idx = v.corrupt; drop_idx = v.drop; start_mid = v.start_mid;
    tx_cnt = 0; done_cnt = 0; tx_log.delete();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    // Start sampled one edge ago: SEND strobes and busy visible now.
    chk({nm, "_first_cycle"}, {busy, tx_dv, gen_en}, 3'b111);
    if (first) chk({nm, "_first_byte"}, tx_byte, 8'hE1);
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_done_seen"}, (k < 3000), 1);
    chk({nm, "_busy_at_done"}, busy, 0);
    chk({nm, "_pass"}, pass, v.exp_pass);
    chk({nm, "_err"}, err_cnt, v.exp_err);
    chk({nm, "_bytes"}, byte_cnt, NB);
    repeat (3) @(negedge clk);
    chk({nm, "_pass_held"}, pass, v.exp_pass);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_tx_pulses"}, tx_cnt, v.exp_tx);
    // CHECK lands TMO cycles after the strobe; the count shows one cycle later.
    if (v.drop >= 0)
      chk({nm, "_timeout_gap"}, cnt_at[v.drop] - dv_at[v.drop], TMO + 1);
    chk_tx_log(nm);
  endtask

  initial begin
    vec_t  tbl[6];
    string names[6];
    int    k;
    tbl[0] = '{10, 10, -1, -1, 0, 0, 1, 4}; names[0] = "clean";
    tbl[1] = '{10, 10,  1, -1, 0, 1, 0, 4}; names[1] = "corrupt";
    tbl[2] = '{10, 10, -1,  2, 0, 1, 0, 4}; names[2] = "lost";
    tbl[3] = '{10, 49, -1, -1, 0, 0, 1, 4}; names[3] = "race";
    tbl[4] = '{10, 50, -1, -1, 0, 4, 0, 4}; names[4] = "late";
    tbl[5] = '{ 3, 12, -1, -1, 1, 0, 1, 4}; names[5] = "start_mid";

    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, pass, tx_dv, gen_en, tx_byte, err_cnt, byte_cnt}, 0);
    rst_n = 1'b1;

    // Stray RX in IDLE must not count or start anything.
    @(negedge clk) begin rx_dv_s = 1'b1; rx_byte_s = 8'h55; end
    @(negedge clk) rx_dv_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_rx_idle", {busy, tx_dv, err_cnt, byte_cnt}, 0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], names[i], i == 0);

    // Reset during the second WAIT.
    tx_dly = 10; rx_dly = 10; corrupt_idx = -1; drop_idx = -1; start_mid = 0;
    tx_cnt = 0; tx_log.delete();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    k = 0;
    while (tx_cnt < 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("midrst_reached_2nd_tx", (k < 500), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    chk("midrst_outputs", {busy, done, pass, tx_dv, gen_en, tx_byte, err_cnt, byte_cnt}, 0);
    repeat (20) @(negedge clk);
    chk("midrst_stays_idle", {busy, tx_dv, err_cnt, byte_cnt}, 0);
    chk("midrst_tx_pulses", tx_cnt, 2);
    chk_tx_log("midrst");
    run_vec(tbl[0], "after_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
